store_buffer: RTL and testbench

In-order store buffer for the execute/memory boundary. It allocates a slot per store at dispatch and captures each store's address and data from the LSU store writeback. It answers load-bypass queries combinationally, marks stores committed on ROB retirement, and drains committed stores to data memory through a valid/ready port. Uncommitted stores are squashed on mispredict.

---
 rtl/store_buffer_pkg.sv | 33 +++
 rtl/store_buffer_if.sv | 12 +
 rtl/sb_bypass_sel.sv | 43 ++++
 rtl/store_buffer.sv | 99 +++++++++
 tb/tb_store_buffer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the in-order store buffer.
// Load forwarding is enabled by defining SB_LD_BYPASS_EN.
package store_buffer_pkg;

  localparam int SB_ENTRY    = 8;
  localparam int WORD_SIZE_P = 16;
  localparam int SB_IDX_W    = $clog2(SB_ENTRY);

  typedef logic [SB_IDX_W-1:0]    sb_idx_t;
  typedef logic [WORD_SIZE_P-1:0] sb_word_t;

  typedef struct packed {
    sb_idx_t  sb_dest;
    sb_word_t address;
    sb_word_t result;
  } CDB_sb_t;

  localparam int CDB_SB_WIDTH = $bits(CDB_sb_t);

  typedef struct packed {
    logic     alloc;
    logic     addr_v;
    logic     committed;
    sb_word_t address;
    sb_word_t data;
  } sb_entry_t;

  // Circular distance from base to idx; pointer width gives the modulo for free.
  function automatic sb_idx_t sb_dist(sb_idx_t idx, sb_idx_t base);
    return idx - base;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Drain port from the store buffer to data memory (valid/ready).
interface store_buffer_if
  import store_buffer_pkg::*;
();
  logic     mem_w_v;
  sb_word_t mem_w_addr;
  sb_word_t mem_w_data;
  logic     mem_w_ready;

  modport master (output mem_w_v, mem_w_addr, mem_w_data, input mem_w_ready);
  modport slave  (input mem_w_v, mem_w_addr, mem_w_data, output mem_w_ready);
endinterface

// File: rtl/sb_bypass_sel.sv
// Youngest-older-store forwarding search; only built when SB_LD_BYPASS_EN is defined.
`ifdef SB_LD_BYPASS_EN
module sb_bypass_sel
  import store_buffer_pkg::*;
(
  input  sb_entry_t entries [SB_ENTRY],
  input  sb_idx_t   head,
  input  sb_idx_t   sb_num,
  input  sb_word_t  addr,
  output logic      hit,
  output sb_word_t  value
);

  sb_idx_t limit;
  sb_idx_t best;
  logic    unused_flags;

  // Candidates are strictly older than the load; the largest distance from head is youngest.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    best  = '0;
    limit = sb_dist(sb_num, head);
    for (int i = 0; i < SB_ENTRY; i++) begin
      if (entries[i].addr_v && (entries[i].address == addr) &&
          (sb_dist(sb_idx_t'(i), head) < limit) &&
          (!hit || (sb_dist(sb_idx_t'(i), head) > best))) begin
        hit   = 1'b1;
        value = entries[i].data;
        best  = sb_dist(sb_idx_t'(i), head);
      end
    end
  end

  always_comb begin
    unused_flags = 1'b0;
    for (int i = 0; i < SB_ENTRY; i++) begin
      unused_flags = unused_flags ^ entries[i].alloc ^ entries[i].committed;
    end
  end

endmodule
`endif

// File: rtl/store_buffer.sv
// In-order store buffer: alloc at dispatch, LSU writeback, ROB commit, drain to memory.
// Optional load forwarding is built when SB_LD_BYPASS_EN is defined.
module store_buffer
  import store_buffer_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_n_i,
  input  logic     alloc_v_i,
  output sb_idx_t  alloc_idx_o,
  output logic     sb_full_o,
  input  logic     lsu_sb_v_i,
  input  CDB_sb_t  lsu_sb_i,
  input  sb_word_t exe_ld_bypass_addr_i,
  input  sb_idx_t  exe_ld_bypass_sb_num_i,
  output logic     sb_ld_bypass_valid_o,
  output sb_word_t sb_ld_bypass_value_o,
  input  logic     commit_v_i,
  input  logic     mispredict_i,
  store_buffer_if.master mem
);

  sb_entry_t entries [SB_ENTRY];
  sb_idx_t   head, cmt, tail, cmt_nxt;
  logic      full, do_alloc, do_wb, do_commit, do_drain;
  logic      unused_committed;

  assign full      = (sb_dist(tail, head) == sb_idx_t'(SB_ENTRY - 1));
  assign do_alloc  = alloc_v_i && !full && !mispredict_i;
  assign do_wb     = lsu_sb_v_i && !mispredict_i && entries[lsu_sb_i.sb_dest].alloc;
  assign do_commit = commit_v_i && (cmt != tail) && entries[cmt].addr_v;
  assign do_drain  = (head != cmt) && mem.mem_w_ready;
  assign cmt_nxt   = cmt + sb_idx_t'(do_commit);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + sb_idx_t'(do_drain);
      cmt  <= cmt_nxt;
      tail <= mispredict_i ? cmt_nxt : tail + sb_idx_t'(do_alloc);
    end
  end

  // Squash spans [cmt_nxt, tail) so a same-cycle commit survives; drain clear is applied last.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SB_ENTRY; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < SB_ENTRY; i++) begin
        if (mispredict_i && (sb_dist(sb_idx_t'(i), cmt_nxt) < sb_dist(tail, cmt_nxt))) begin
          entries[i].alloc  <= 1'b0;
          entries[i].addr_v <= 1'b0;
        end
      end
      if (do_alloc) begin
        entries[tail].alloc     <= 1'b1;
        entries[tail].addr_v    <= 1'b0;
        entries[tail].committed <= 1'b0;
      end
      if (do_wb) begin
        entries[lsu_sb_i.sb_dest].address <= lsu_sb_i.address;
        entries[lsu_sb_i.sb_dest].data    <= lsu_sb_i.result;
        entries[lsu_sb_i.sb_dest].addr_v  <= 1'b1;
      end
      if (do_commit) entries[cmt].committed <= 1'b1;
      if (do_drain)  entries[head] <= '0;
    end
  end

  assign alloc_idx_o    = tail;
  assign sb_full_o      = full;
  assign mem.mem_w_v    = (head != cmt);
  assign mem.mem_w_addr = entries[head].address;
  assign mem.mem_w_data = entries[head].data;

  always_comb begin
    unused_committed = 1'b0;
    for (int i = 0; i < SB_ENTRY; i++) unused_committed = unused_committed ^ entries[i].committed;
  end

`ifdef SB_LD_BYPASS_EN
  sb_bypass_sel u_bypass_sel (
    .entries (entries),
    .head    (head),
    .sb_num  (exe_ld_bypass_sb_num_i),
    .addr    (exe_ld_bypass_addr_i),
    .hit     (sb_ld_bypass_valid_o),
    .value   (sb_ld_bypass_value_o)
  );
`else
  logic unused_query;
  assign unused_query         = ^{exe_ld_bypass_addr_i, exe_ld_bypass_sb_num_i};
  assign sb_ld_bypass_valid_o = 1'b0;
  assign sb_ld_bypass_value_o = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized bench for store_buffer against a queue-based reference model.
module tb_store_buffer;
  import store_buffer_pkg::*;

`ifdef SB_LD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic     clk_i = 1'b0;
  logic     reset_n_i;
  logic     alloc_v_i, sb_full_o, lsu_sb_v_i, commit_v_i, mispredict_i;
  logic     sb_ld_bypass_valid_o;
  sb_idx_t  alloc_idx_o, exe_ld_bypass_sb_num_i;
  CDB_sb_t  lsu_sb_i;
  sb_word_t exe_ld_bypass_addr_i, sb_ld_bypass_value_o;

  store_buffer_if mem ();

  store_buffer dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .alloc_v_i              (alloc_v_i),
    .alloc_idx_o            (alloc_idx_o),
    .sb_full_o              (sb_full_o),
    .lsu_sb_v_i             (lsu_sb_v_i),
    .lsu_sb_i               (lsu_sb_i),
    .exe_ld_bypass_addr_i   (exe_ld_bypass_addr_i),
    .exe_ld_bypass_sb_num_i (exe_ld_bypass_sb_num_i),
    .sb_ld_bypass_valid_o   (sb_ld_bypass_valid_o),
    .sb_ld_bypass_value_o   (sb_ld_bypass_value_o),
    .commit_v_i             (commit_v_i),
    .mispredict_i           (mispredict_i),
    .mem                    (mem)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: program-order queue of live stores; the first ncmt are committed.
  typedef struct {
    int          slot;
    logic [15:0] addr;
    logic [15:0] data;
    bit          addr_v;
  } st_t;

  st_t q[$];
  int  head_m = 0;
  int  ncmt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_slot(input int s);
    for (int k = 0; k < q.size(); k++) if (q[k].slot == s) return k;
    return -1;
  endfunction

  task automatic exp_bypass(input logic [15:0] a, input int num, output logic v, output logic [15:0] val);
    int pos;
    pos = (num - head_m + 8) % 8;
    v   = 1'b0;
    val = '0;
    for (int k = 0; k < q.size() && k < pos; k++) begin
      if (q[k].addr_v && q[k].addr == a) begin
        v   = 1'b1;
        val = q[k].data;
      end
    end
    if (!BYP) begin
      v   = 1'b0;
      val = '0;
    end
  endtask

  task automatic step(input int al, input int wv, input int dest, input logic [15:0] wa,
                      input logic [15:0] wd, input int cm, input int rdy, input int mp,
                      input logic [15:0] qa, input int qn);
    logic        ev;
    logic [15:0] eval;
    bit          wb_ok, cm_ok, dr_ok, al_ok;
    int          k;
    @(negedge clk_i);
    alloc_v_i              = (al != 0);
    lsu_sb_v_i             = (wv != 0);
    lsu_sb_i               = '{sb_dest: sb_idx_t'(dest), address: wa, result: wd};
    commit_v_i             = (cm != 0);
    mem.mem_w_ready        = (rdy != 0);
    mispredict_i           = (mp != 0);
    exe_ld_bypass_addr_i   = qa;
    exe_ld_bypass_sb_num_i = sb_idx_t'(qn);
    #1;
    chk("alloc_idx", 32'(alloc_idx_o), 32'((head_m + q.size()) % 8));
    chk("full", 32'(sb_full_o), 32'(q.size() == 7));
    chk("mem_v", 32'(mem.mem_w_v), 32'(ncmt > 0));
    if (ncmt > 0) begin
      chk("mem_addr", 32'(mem.mem_w_addr), 32'(q[0].addr));
      chk("mem_data", 32'(mem.mem_w_data), 32'(q[0].data));
    end
    exp_bypass(qa, qn, ev, eval);
    chk("byp_v", 32'(sb_ld_bypass_valid_o), 32'(ev));
    chk("byp_val", 32'(sb_ld_bypass_value_o), 32'(eval));
    k     = find_slot(dest);
    wb_ok = (wv != 0) && (mp == 0) && (k >= 0);
    cm_ok = (cm != 0) && (ncmt < q.size()) && q[ncmt].addr_v;
    dr_ok = (rdy != 0) && (ncmt > 0);
    al_ok = (al != 0) && (mp == 0) && (q.size() < 7);
    @(posedge clk_i);
    if (wb_ok) begin
      q[k].addr   = wa;
      q[k].data   = wd;
      q[k].addr_v = 1'b1;
    end
    if (cm_ok) ncmt++;
    if (dr_ok) begin
      void'(q.pop_front());
      ncmt--;
      head_m = (head_m + 1) % 8;
    end
    if (mp != 0) while (q.size() > ncmt) void'(q.pop_back());
    if (al_ok) q.push_back('{slot: (head_m + q.size()) % 8, addr: 16'h0, data: 16'h0, addr_v: 1'b0});
  endtask

  task automatic s_alloc();                     step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic s_wb(input int d, input logic [15:0] a, input logic [15:0] v);
                                                step(0, 1, d, a, v, 0, 0, 0, 0, 0); endtask
  task automatic s_commit(input int rdy);       step(0, 0, 0, 0, 0, 1, rdy, 0, 0, 0); endtask
  task automatic s_idle(input int rdy);         step(0, 0, 0, 0, 0, 0, rdy, 0, 0, 0); endtask
  task automatic s_query(input logic [15:0] a, input int n);
                                                step(0, 0, 0, 0, 0, 0, 0, 0, a, n); endtask

  task automatic idle_inputs();
    alloc_v_i              = 1'b0;
    lsu_sb_v_i             = 1'b0;
    lsu_sb_i               = '0;
    commit_v_i             = 1'b0;
    mem.mem_w_ready        = 1'b0;
    mispredict_i           = 1'b0;
    exe_ld_bypass_addr_i   = '0;
    exe_ld_bypass_sb_num_i = '0;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    q.delete();
    head_m = 0;
    ncmt   = 0;
  endtask

  initial begin
    logic [15:0] atab [4];
    atab = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};

    // Reset state
    reset_n_i = 1'b0;
    idle_inputs();
    #3;
    chk("rst_alloc_idx", 32'(alloc_idx_o), 32'd0);
    chk("rst_full", 32'(sb_full_o), 32'd0);
    chk("rst_mem_v", 32'(mem.mem_w_v), 32'd0);
    chk("rst_mem_addr", 32'(mem.mem_w_addr), 32'd0);
    chk("rst_mem_data", 32'(mem.mem_w_data), 32'd0);
    do_reset();

    // Basic commit and drain
    repeat (3) s_alloc();
    s_wb(0, 16'h0040, 16'hAAAA);
    s_commit(1);
    #1;
    chk("t1_mem_v", 32'(mem.mem_w_v), 32'd1);
    chk("t1_mem_addr", 32'(mem.mem_w_addr), 32'h0040);
    chk("t1_mem_data", 32'(mem.mem_w_data), 32'hAAAA);
    s_idle(1);
    #1;
    chk("t1_drained", 32'(mem.mem_w_v), 32'd0);
    chk("t1_tail", 32'(alloc_idx_o), 32'd3);

    // Fill to capacity; the extra alloc is ignored
    do_reset();
    repeat (7) s_alloc();
    #1;
    chk("t2_full", 32'(sb_full_o), 32'd1);
    chk("t2_idx7", 32'(alloc_idx_o), 32'd7);
    s_alloc();
    #1;
    chk("t2_idx_hold", 32'(alloc_idx_o), 32'd7);
    chk("t2_still_full", 32'(sb_full_o), 32'd1);

    // Youngest older match wins
    do_reset();
    repeat (2) s_alloc();
    s_wb(0, 16'h0010, 16'h1111);
    s_wb(1, 16'h0010, 16'h2222);
    s_query(16'h0010, 2);
    #1;
    chk("t3_n2_v", 32'(sb_ld_bypass_valid_o), 32'(BYP));
    chk("t3_n2_val", 32'(sb_ld_bypass_value_o), BYP ? 32'h2222 : 32'h0);
    s_query(16'h0010, 1);
    #1;
    chk("t3_n1_val", 32'(sb_ld_bypass_value_o), BYP ? 32'h1111 : 32'h0);
    s_query(16'h0010, 0);
    #1;
    chk("t3_n0_v", 32'(sb_ld_bypass_valid_o), 32'd0);

    // Mispredict squashes uncommitted stores
    do_reset();
    repeat (4) s_alloc();
    for (int i = 0; i < 4; i++) s_wb(i, 16'h0050 + 16'(i), 16'h5000 + 16'(i));
    repeat (2) s_commit(0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("t4_tail", 32'(alloc_idx_o), 32'd2);
    s_query(16'h0052, 4);
    #1;
    chk("t4_squashed_miss", 32'(sb_ld_bypass_valid_o), 32'd0);
    s_query(16'h0051, 4);
    #1;
    chk("t4_committed_hit", 32'(sb_ld_bypass_value_o), BYP ? 32'h5001 : 32'h0);

    // Pointer wrap with ordered drains
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_alloc();
      s_wb(i % 8, 16'h0100 + 16'(i), 16'h7000 + 16'(i));
      s_commit(0);
      #1;
      chk("t5_order", 32'(mem.mem_w_addr), 32'h0100 + 32'(i));
      s_idle(1);
    end
    #1;
    chk("t5_wrap_tail", 32'(alloc_idx_o), 32'd4);

    // Async reset mid-drain
    do_reset();
    s_alloc();
    s_wb(0, 16'h0077, 16'h1234);
    s_commit(0);
    @(negedge clk_i);
    exe_ld_bypass_addr_i   = 16'h0077;
    exe_ld_bypass_sb_num_i = 3'd1;
    #2;
    chk("t6_pre_v", 32'(mem.mem_w_v), 32'd1);
    reset_n_i = 1'b0;
    #1;
    chk("t6_mem_v", 32'(mem.mem_w_v), 32'd0);
    chk("t6_mem_addr", 32'(mem.mem_w_addr), 32'd0);
    chk("t6_mem_data", 32'(mem.mem_w_data), 32'd0);
    chk("t6_idx", 32'(alloc_idx_o), 32'd0);
    chk("t6_byp_v", 32'(sb_ld_bypass_valid_o), 32'd0);
    chk("t6_byp_val", 32'(sb_ld_bypass_value_o), 32'd0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), (head_m + $urandom_range(0, 7)) % 8,
           atab[$urandom_range(0, 3)], 16'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 15) == 0) ? 1 : 0,
           atab[$urandom_range(0, 3)], $urandom_range(0, 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
